sram_port_arbiter: RTL

- Shares one SRAM-like memory port between the instruction-fetch requester and the data requester of the 5-stage core.
- Sits between the core's inst_sram/data_sram side and the single external memory bridge.
- Grants one request per cycle and tracks outstanding transactions in an in-order ID FIFO, so each mem_data_ok is routed back to the requester that issued it.
- Raises a stall request to CTRL while a data access waits for its grant.

---
 rtl/sram_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, routing
// in-order responses via an ID FIFO. Optional counters enabled by SRAM_ARB_STAT_EN.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_OUTS = 2
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        inst_req,
    input  logic [ADDR_W-1:0]           inst_addr,
    output logic                        inst_addr_ok,
    output logic                        inst_data_ok,
    output logic [DATA_W-1:0]           inst_rdata,

    input  logic                        data_req,
    input  logic                        data_wr,
    input  logic [1:0]                  data_size,
    input  logic [3:0]                  data_wstrb,
    input  logic [ADDR_W-1:0]           data_addr,
    input  logic [DATA_W-1:0]           data_wdata,
    output logic                        data_addr_ok,
    output logic                        data_data_ok,
    output logic [DATA_W-1:0]           data_rdata,

    output logic                        mem_req,
    output logic                        mem_wr,
    output logic [1:0]                  mem_size,
    output logic [3:0]                  mem_wstrb,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_addr_ok,
    input  logic                        mem_data_ok,
    input  logic [DATA_W-1:0]           mem_rdata,

    output logic                        stallreq_for_mem,
    output logic [$clog2(MAX_OUTS):0]   outs_cnt,
    output logic                        err
`ifdef SRAM_ARB_STAT_EN
    ,
    output logic [31:0]                 stat_conflict,
    output logic [31:0]                 stat_full
`endif
);

    localparam int unsigned CntW = $clog2(MAX_OUTS) + 1;
    localparam int unsigned PtrW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam logic [CntW-1:0] CntFull = CntW'(MAX_OUTS);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTS - 1);

    logic                locked_q, locked_d;
    logic                lock_id_q, lock_id_d;
    logic [MAX_OUTS-1:0] id_q, id_d;
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;

    logic full;
    logic empty;
    logic grant_data;
    logic granted_req;
    logic req_ok;
    logic accept;
    logic pop;
    logic head_data;

    // A locked grant overrides the fixed data-first priority until its handshake completes.
    always_comb begin
        full        = (cnt_q == CntFull);
        empty       = (cnt_q == '0);
        grant_data  = locked_q ? lock_id_q : data_req;
        granted_req = grant_data ? data_req : inst_req;
        req_ok      = rst & ~full & granted_req;
        accept      = req_ok & mem_addr_ok;
        pop         = mem_data_ok & ~empty;
        head_data   = id_q[rptr_q];
    end

    always_comb begin
        mem_req          = req_ok;
        mem_wr           = 1'b0;
        mem_size         = 2'd0;
        mem_wstrb        = 4'd0;
        mem_addr         = '0;
        mem_wdata        = '0;
        inst_addr_ok     = accept & ~grant_data;
        data_addr_ok     = accept & grant_data;
        inst_data_ok     = rst & pop & ~head_data;
        data_data_ok     = rst & pop & head_data;
        inst_rdata       = '0;
        data_rdata       = '0;
        stallreq_for_mem = rst & data_req & ~(accept & grant_data);
        outs_cnt         = cnt_q;
        err              = err_q;
        if (rst) begin
            if (grant_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
        if (inst_data_ok) begin
            inst_rdata = mem_rdata;
        end
        if (data_data_ok) begin
            data_rdata = mem_rdata;
        end
    end

    always_comb begin
        locked_d  = locked_q;
        lock_id_d = lock_id_q;
        id_d      = id_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q | (mem_data_ok & empty);

        if (accept) begin
            locked_d     = 1'b0;
            id_d[wptr_q] = grant_data;
            wptr_d       = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
        end else if (req_ok) begin
            locked_d  = 1'b1;
            lock_id_d = grant_data;
        end

        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end

        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_q  <= 1'b0;
            lock_id_q <= 1'b0;
            id_q      <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            lock_id_q <= lock_id_d;
            id_q      <= id_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef SRAM_ARB_STAT_EN
    logic [31:0] stat_conflict_q, stat_conflict_d;
    logic [31:0] stat_full_q, stat_full_d;

    always_comb begin
        stat_conflict_d = stat_conflict_q + 32'(inst_req & data_req);
        stat_full_d     = stat_full_q + 32'(full & (inst_req | data_req));
        stat_conflict   = stat_conflict_q;
        stat_full       = stat_full_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_conflict_q <= '0;
            stat_full_q     <= '0;
        end else begin
            stat_conflict_q <= stat_conflict_d;
            stat_full_q     <= stat_full_d;
        end
    end
`endif

    cnt_bounded: assert property (@(posedge clk) disable iff (!rst) cnt_q <= CntFull);

endmodule
